// File: rtl/net_mem_responder_pkg.sv
// Shared definitions for the remote memory responder: message codes carried on
// msg_in/msg_out and the responder FSM state encoding.
package net_mem_responder_pkg;

    // Message codes. Any code not listed is ignored while idle.
    localparam int MSG_NO_REQ   = 0;
    localparam int MSG_WB_REQ   = 1;
    localparam int MSG_R_REQ    = 2;
    localparam int MSG_MEM_RESP = 7;
    localparam int MSG_MEM_DONE = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_COLLECT,
        S_RD_WAIT,
        S_RD_SEND,
        S_DONE,
        S_QUIESCE
    } nmr_state_e;

endpackage

// File: rtl/net_mem_responder_line_buffer.sv
// Writeback line buffer: one register per word of a line plus a count of the
// words received so far. clear drops the whole line (abort or after commit).
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   clear             empty the buffer (wins over wr_en)
//   wr_en/wr_off/wr_data  store one word at the given line offset, count++
//   line              current buffer contents, offset j in line[j]
//   count             number of words written since the last clear
module net_mem_responder_line_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int OFFSET_BITS = 2
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          clear,
    input  logic                                          wr_en,
    input  logic [OFFSET_BITS-1:0]                        wr_off,
    input  logic [DATA_WIDTH-1:0]                         wr_data,
    output logic [(1<<OFFSET_BITS)-1:0][DATA_WIDTH-1:0]   line,
    output logic [OFFSET_BITS:0]                          count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line  <= '0;
            count <= '0;
        end else if (clear) begin
            line  <= '0;
            count <= '0;
        end else if (wr_en) begin
            line[wr_off] <= wr_data;
            count        <= count + 1'b1;
        end
    end

endmodule

// File: rtl/net_mem_responder.sv
// Remote memory node: accepts line writebacks and line reads as word-serial
// message streams and answers from a word-addressed backing store.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   msg_in              request code (NO_REQ / WB_REQ / R_REQ)
//   address_in          word address of the current request word
//   data_in             writeback word
//   msg_out             response code (NO_REQ / MEM_RESP / MEM_DONE), registered
//   address_out         word address of the response word, registered
//   data_out            read response word, registered
// Storage is not reset; only the control state and outputs are.
module net_mem_responder
    import net_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4,
    parameter int OFFSET_BITS   = 2,
    parameter int INDEX_BITS    = 10,
    parameter int READ_LATENCY  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MSG_BITS-1:0]      msg_in,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [MSG_BITS-1:0]      msg_out,
    output logic [ADDRESS_WIDTH-1:0] address_out,
    output logic [DATA_WIDTH-1:0]    data_out
);

    localparam int WORDS = 1 << OFFSET_BITS;
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int CNT_W = OFFSET_BITS + 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    nmr_state_e                 state;
    logic [ADDRESS_WIDTH-1:0]   base;
    logic [LAT_W-1:0]           lat;
    logic [CNT_W-1:0]           k;      // next read word offset; WORDS means all sent

    logic [DATA_WIDTH-1:0]      mem [DEPTH];

    logic                       is_none, is_wb, is_rd;
    logic [ADDRESS_WIDTH-1:0]   in_base;
    logic [OFFSET_BITS-1:0]     in_off;

    logic                       buf_wr, buf_clear, last_word, commit;
    logic [WORDS-1:0][DATA_WIDTH-1:0] buf_line, merged;
    logic [CNT_W-1:0]           buf_count;

    logic [INDEX_BITS-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0]      rd_data;

    assign is_none = (msg_in == MSG_BITS'(MSG_NO_REQ));
    assign is_wb   = (msg_in == MSG_BITS'(MSG_WB_REQ));
    assign is_rd   = (msg_in == MSG_BITS'(MSG_R_REQ));
    assign in_base = {address_in[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign in_off  = address_in[OFFSET_BITS-1:0];

    // Completion is by word count only; repeated offsets still count.
    assign last_word = (buf_count == CNT_W'(WORDS - 1));
    assign buf_wr    = is_wb && (state == S_IDLE || state == S_WB_COLLECT);
    assign commit    = (state == S_WB_COLLECT) && is_wb && last_word;
    assign buf_clear = (state == S_WB_COLLECT) && (!is_wb || last_word);

    net_mem_responder_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFFSET_BITS(OFFSET_BITS)
    ) u_line_buffer (
        .clock  (clock),
        .reset  (reset),
        .clear  (buf_clear),
        .wr_en  (buf_wr),
        .wr_off (in_off),
        .wr_data(data_in),
        .line   (buf_line),
        .count  (buf_count)
    );

    // The final word bypasses the buffer so the whole line lands in storage
    // in the same cycle it arrives.
    always_comb begin
        for (int j = 0; j < WORDS; j++) begin
            merged[j] = (in_off == OFFSET_BITS'(j)) ? data_in : buf_line[j];
        end
    end

    always_ff @(posedge clock) begin
        if (commit) begin
            for (int j = 0; j < WORDS; j++) begin
                mem[base[INDEX_BITS-1:0] | INDEX_BITS'(j)] <= merged[j];
            end
        end
    end

    assign rd_idx  = base[INDEX_BITS-1:0] | INDEX_BITS'(k[OFFSET_BITS-1:0]);
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            msg_out     <= MSG_BITS'(MSG_NO_REQ);
            address_out <= '0;
            data_out    <= '0;
            base        <= '0;
            lat         <= '0;
            k           <= '0;
        end else begin
            msg_out     <= MSG_BITS'(MSG_NO_REQ);
            address_out <= '0;
            data_out    <= '0;
            case (state)
                S_IDLE: begin
                    if (is_wb) begin
                        base  <= in_base;
                        state <= S_WB_COLLECT;
                    end else if (is_rd) begin
                        base  <= in_base;
                        lat   <= '0;
                        k     <= '0;
                        state <= S_RD_WAIT;
                    end
                end
                S_WB_COLLECT: begin
                    // Any code other than WB_REQ aborts; buffer is cleared above.
                    if (!is_wb) begin
                        state <= S_IDLE;
                    end else if (last_word) begin
                        msg_out     <= MSG_BITS'(MSG_MEM_DONE);
                        address_out <= base;
                        state       <= S_DONE;
                    end
                end
                S_RD_WAIT: begin
                    if (!is_rd) begin
                        state <= S_IDLE;
                    end else if (lat == LAT_W'(READ_LATENCY - 1)) begin
                        msg_out     <= MSG_BITS'(MSG_MEM_RESP);
                        address_out <= base | ADDRESS_WIDTH'(k[OFFSET_BITS-1:0]);
                        data_out    <= rd_data;
                        k           <= k + 1'b1;
                        state       <= S_RD_SEND;
                    end else begin
                        lat <= lat + 1'b1;
                    end
                end
                S_RD_SEND: begin
                    if (!is_rd) begin
                        state <= S_IDLE;
                    end else if (k == CNT_W'(WORDS)) begin
                        msg_out     <= MSG_BITS'(MSG_MEM_DONE);
                        address_out <= base;
                        state       <= S_DONE;
                    end else begin
                        msg_out     <= MSG_BITS'(MSG_MEM_RESP);
                        address_out <= base | ADDRESS_WIDTH'(k[OFFSET_BITS-1:0]);
                        data_out    <= rd_data;
                        k           <= k + 1'b1;
                    end
                end
                // MEM_DONE is visible during this state; wait for the
                // requester to release before accepting anything new.
                S_DONE:    state <= is_none ? S_IDLE : S_QUIESCE;
                S_QUIESCE: if (is_none) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule
